// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
// Contents:
//   mode_t    : pattern mode codes (OFF / SHIFT / BOUNCE / COUNT)
//   dir_t     : bounce direction (LEFT / RIGHT)
//   SEED_*    : LSB of the value loaded into the LEDs on a mode change
//               (all upper bits of a seed are zero)
//   seed_bit  : maps a mode to its seed LSB
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic SEED_OFF    = 1'b0;
  localparam logic SEED_SHIFT  = 1'b1;
  localparam logic SEED_BOUNCE = 1'b1;
  localparam logic SEED_COUNT  = 1'b0;

  function automatic logic seed_bit(input mode_t m);
    case (m)
      MODE_OFF:    seed_bit = SEED_OFF;
      MODE_SHIFT:  seed_bit = SEED_SHIFT;
      MODE_BOUNCE: seed_bit = SEED_BOUNCE;
      default:     seed_bit = SEED_COUNT;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Board-side signal bundle of the LED pattern sequencer.
// Signals:
//   tick_in    : 1 Hz level from the clock divider, async to the sequencer clock
//   sw[2:0]    : raw switches, sw[1:0] mode, sw[2] pause
//   led        : LED pattern output (LED_W bits)
//   step_pulse : one-cycle pulse per accepted tick rising edge
//   mode_out   : currently registered mode
// Modports: master drives tick_in/sw (board/bench side), slave is the sequencer.
interface led_pattern_seq_if #(
  parameter int LED_W = 4
);
  logic             tick_in;
  logic [2:0]       sw;
  logic [LED_W-1:0] led;
  logic             step_pulse;
  logic [1:0]       mode_out;

  modport master (output tick_in, output sw,
                  input  led, input step_pulse, input mode_out);
  modport slave  (input  tick_in, input sw,
                  output led, output step_pulse, output mode_out);
endinterface

// File: rtl/sw_debounce.sv
// One switch input conditioner: SYNC_STAGES-flop synchronizer, optionally
// followed by a stability filter when DEBOUNCE_EN is defined.
// With DEBOUNCE_EN the output only follows the synchronized input after it
// has differed from the current output for DEB_CYCLES consecutive cycles.
// Without it the output is the synchronized input.
// Ports:
//   clk_in : sequencer clock
//   rst    : asynchronous reset, active-high
//   raw    : raw switch level
//   deb    : conditioned switch level (0 after reset)
module sw_debounce
  import led_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 50000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   synced;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) sync_p <= '0;
    else     sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
  end

  assign synced = sync_p[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             deb_q;

  // Counter runs only while the input disagrees with the accepted level;
  // the last count of a full run is the cycle the new level is taken.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      deb_q <= 1'b0;
    end else if (synced == deb_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      deb_q <= synced;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign deb = deb_q;
`else
  assign deb = synced;
`endif

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer in the 5 MHz domain. Steps an LED pattern on each
// rising edge of the divider's 1 Hz output, which is synchronized and
// edge-detected here. Switches select the mode and pause.
// Optional feature: DEBOUNCE_EN (switch stability filter in sw_debounce).
// Ports:
//   clk_in : 5 MHz clock
//   rst    : asynchronous reset, active-high
//   io     : led_pattern_seq_if.slave (tick_in, sw in; led, step_pulse, mode_out out)
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int LED_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 50000
) (
  input  logic                clk_in,
  input  logic                rst,
  led_pattern_seq_if.slave    io
);

  logic [SYNC_STAGES-1:0] tick_sync_p;
  logic [SYNC_STAGES-1:0] fill_p;
  logic                   ts;
  logic                   tp;
  logic                   armed;
  logic                   step_q;

  logic [2:0]             sw_deb;
  mode_t                  deb_mode;
  logic                   pause;

  mode_t                  mode_q, mode_d;
  dir_t                   dir_q, dir_d;
  logic [LED_W-1:0]       led_q, led_d;

  assign ts = tick_sync_p[SYNC_STAGES-1];

  // Tick synchronizer and rising-edge detector.
  // fill_p marks when ts carries a real post-reset sample: arming on the
  // reset-cleared chain would turn a tick already high at release into a
  // false edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tick_sync_p <= '0;
      fill_p      <= '0;
      tp          <= 1'b0;
      armed       <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      tick_sync_p <= {tick_sync_p[SYNC_STAGES-2:0], io.tick_in};
      fill_p      <= {fill_p[SYNC_STAGES-2:0], 1'b1};
      tp          <= ts;
      if (fill_p[SYNC_STAGES-1] && !ts) armed <= 1'b1;
      step_q      <= armed & ts & ~tp;
    end
  end

  // Switch conditioning, one instance per switch bit.
  for (genvar i = 0; i < 3; i++) begin : g_sw
    sw_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_deb (
      .clk_in (clk_in),
      .rst    (rst),
      .raw    (io.sw[i]),
      .deb    (sw_deb[i])
    );
  end

  assign deb_mode = mode_t'(sw_deb[1:0]);
  assign pause    = sw_deb[2];

  // Mode / pattern next state. A mode reload takes priority over a step
  // landing in the same cycle; that step is simply lost.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    led_d  = led_q;
    if (deb_mode != mode_q) begin
      mode_d = deb_mode;
      dir_d  = DIR_LEFT;
      led_d  = {{(LED_W-1){1'b0}}, seed_bit(deb_mode)};
    end else if (step_q && !pause) begin
      case (mode_q)
        MODE_OFF:    led_d = '0;
        MODE_SHIFT:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            if (led_q[LED_W-1]) begin
              led_d = led_q >> 1;
              dir_d = DIR_RIGHT;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_d = led_q << 1;
              dir_d = DIR_LEFT;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default:     led_d = led_q + LED_W'(1);
      endcase
    end
  end

  // Pattern state registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_OFF;
      dir_q  <= DIR_LEFT;
      led_q  <= '0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
    end
  end

  assign io.led        = led_q;
  assign io.step_pulse = step_q;
  assign io.mode_out   = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
module tb_led_pattern_seq;

  localparam int W = 4;
`ifdef DEBOUNCE_EN
  localparam int SW_LAT = 7;   // sw drive edge -> mode reload edge (sync 2 + filter 4 + reg 1)
`else
  localparam int SW_LAT = 3;   // sw drive edge -> mode reload edge (sync 2 + reg 1)
`endif
  localparam int STEP_LAT = 4; // tick drive edge -> led update edge (sync 2 + edge 1 + reg 1)

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [W-1:0] led;
    logic [1:0]   mode;
    int           cyc;
  } exp_t;

  exp_t q[$];

  led_pattern_seq_if #(.LED_W(W)) io ();

  led_pattern_seq #(
    .LED_W       (W),
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4)
  ) dut (
    .clk_in (clk),
    .rst    (rst),
    .io     (io.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at #1 after a posedge: queue the expectation, then raise tick.
  task automatic raise_tick(input logic [W-1:0] exp_led, input logic [1:0] exp_mode);
    exp_t e;
    e.led  = exp_led;
    e.mode = exp_mode;
    e.cyc  = cyc + 3;
    q.push_back(e);
    io.tick_in = 1'b1;
  endtask

  task automatic finish_tick();
    repeat (6) @(posedge clk);
    #1 io.tick_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [W-1:0] exp_led, input logic [1:0] exp_mode);
    @(posedge clk);
    #1 raise_tick(exp_led, exp_mode);
    finish_tick();
  endtask

  task automatic set_sw(input logic [2:0] v);
    @(posedge clk);
    #1 io.sw = v;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Monitor: every step_pulse must match a queued tick; the following cycle
  // shows the resulting pattern and mode.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (io.step_pulse === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: got step_pulse=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("step_latency", cyc, e.cyc);
          @(negedge clk);
          check("step_width", io.step_pulse, 1'b0);
          check("step_led", io.led, e.led);
          check("step_mode", io.mode_out, e.mode);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] bounce_tab [8];
    bounce_tab = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};

    io.tick_in = 1'b0;
    io.sw      = 3'b000;
    rst        = 1'b1;

    // 1. Reset held with tick toggling, then release with tick high.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 io.tick_in = ~io.tick_in;
      @(negedge clk);
      check("rst_led", io.led, 4'b0000);
      check("rst_step", io.step_pulse, 1'b0);
      check("rst_mode", io.mode_out, 2'b00);
    end
    @(posedge clk);
    #1 io.tick_in = 1'b1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("no_step_high_release", io.step_pulse, 1'b0);
    io.tick_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tick(4'b0000, 2'b00);

    // 2. SHIFT, including wrap 1000 -> 0001.
    set_sw(3'b001);
    check("shift_mode", io.mode_out, 2'b01);
    check("shift_seed", io.led, 4'b0001);
    tick(4'b0010, 2'b01);
    tick(4'b0100, 2'b01);
    tick(4'b1000, 2'b01);
    tick(4'b0001, 2'b01);
    tick(4'b0010, 2'b01);

    // 3. BOUNCE from seed 0001.
    set_sw(3'b010);
    check("bounce_mode", io.mode_out, 2'b10);
    check("bounce_seed", io.led, 4'b0001);
    for (int i = 0; i < 8; i++) tick(bounce_tab[i], 2'b10);

    // 4. COUNT through all-ones wrap, then pause.
    set_sw(3'b011);
    check("count_mode", io.mode_out, 2'b11);
    check("count_seed", io.led, 4'b0000);
    for (int i = 0; i < 17; i++) tick(W'((i + 1) % 16), 2'b11);
    set_sw(3'b111);
    check("pause_mode", io.mode_out, 2'b11);
    for (int i = 0; i < 3; i++) tick(4'b0001, 2'b11);
    set_sw(3'b011);
    check("unpause_led", io.led, 4'b0001);

    // 5. Glitch rejection, then a mode change landing on a step cycle.
`ifdef DEBOUNCE_EN
    @(posedge clk);
    #1 io.sw = 3'b010;
    repeat (2) @(posedge clk);
    #1 io.sw = 3'b011;
    repeat (12) @(posedge clk);
    #1 check("glitch_mode", io.mode_out, 2'b11);
    check("glitch_led", io.led, 4'b0001);
`endif
    tick(4'b0010, 2'b11);
    @(posedge clk);
    #1;
    if (SW_LAT >= STEP_LAT) begin
      io.sw = 3'b010;
      repeat (SW_LAT - STEP_LAT) @(posedge clk);
      #1 raise_tick(4'b0001, 2'b10);
    end else begin
      raise_tick(4'b0001, 2'b10);
      repeat (STEP_LAT - SW_LAT) @(posedge clk);
      #1 io.sw = 3'b010;
    end
    finish_tick();
    check("reload_mode", io.mode_out, 2'b10);
    check("reload_led", io.led, 4'b0001);
    tick(4'b0010, 2'b10);
    tick(4'b0100, 2'b10);

    // 6. Asynchronous reset mid-BOUNCE.
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("async_rst_led", io.led, 4'b0000);
    check("async_rst_mode", io.mode_out, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_mode", io.mode_out, 2'b00);
    repeat (12) @(posedge clk);
    #1 check("resume_mode", io.mode_out, 2'b10);
    check("resume_led", io.led, 4'b0001);
    tick(4'b0010, 2'b10);
    tick(4'b0100, 2'b10);

    repeat (5) @(posedge clk);
    #1 check("pending_steps", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
